// File: rtl/cla_shift_add_mult_ctrl.sv
// Sequential shift-and-add multiplier: one WIDTH-bit adder built from chained 4-bit CLA slices,
// reused for WIDTH iterations behind a start/busy/done handshake. Optional macro: CLA_MULT_SIGNED_EN.
module cla_shift_add_mult_ctrl #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_start,
  input  logic [WIDTH-1:0]   in_A,
  input  logic [WIDTH-1:0]   in_B,
  output logic               out_busy,
  output logic               out_done,
  output logic [2*WIDTH-1:0] out_P
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
`ifdef CLA_MULT_SIGNED_EN
  logic               sign_q, sign_d;
`endif

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [2*WIDTH-1:0] shifted;

  // 4-bit carry-lookahead slice: returns {carry_out, sum}.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [3:0] g, p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  always_comb begin
    logic [4:0] slice;
    addend = q_q[0] ? m_q : '0;
    sum    = '0;
    carry  = 1'b0;
    slice  = '0;
    // NOTE: blocking assignments here are deliberate; the carry must ripple slice to slice within one evaluation.
    for (int s = 0; s < WIDTH / 4; s++) begin
      slice          = cla4(acc_q[s*4 +: 4], addend[s*4 +: 4], carry);
      sum[s*4 +: 4]  = slice[3:0];
      carry          = slice[4];
    end
    shifted = {carry, sum, q_q[WIDTH-1:1]};
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
`ifdef CLA_MULT_SIGNED_EN
    sign_d  = sign_q;
`endif
    case (state_q)
      RUN: begin
        acc_d = shifted[2*WIDTH-1:WIDTH];
        q_d   = shifted[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef CLA_MULT_SIGNED_EN
          p_d = sign_q ? -shifted : shifted;
`else
          p_d = shifted;
`endif
          state_d = DONE;
        end
      end
      default: begin
        // IDLE and DONE both accept a new operation; DONE otherwise falls back to IDLE.
        if (in_start) begin
`ifdef CLA_MULT_SIGNED_EN
          m_d    = in_A[WIDTH-1] ? -in_A : in_A;
          q_d    = in_B[WIDTH-1] ? -in_B : in_B;
          sign_d = in_A[WIDTH-1] ^ in_B[WIDTH-1];
`else
          m_d    = in_A;
          q_d    = in_B;
`endif
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
`ifdef CLA_MULT_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
`ifdef CLA_MULT_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  assign out_busy = (state_q == RUN);
  assign out_done = (state_q == DONE);
  assign out_P    = p_q;

endmodule

// File: tb/tb_cla_shift_add_mult_ctrl.sv
// Directed bench for cla_shift_add_mult_ctrl: WIDTH=4 handshake/product vectors plus one WIDTH=8 vector.
module tb_cla_shift_add_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  p4;
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] p8;

  int errors = 0;
  int checks = 0;
  logic [7:0] prev_p = '0;

  always #5 clk = ~clk;

  cla_shift_add_mult_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_start(start4), .in_A(a4), .in_B(b4),
    .out_busy(busy4), .out_done(done4), .out_P(p4)
  );

  cla_shift_add_mult_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_start(start8), .in_A(a8), .in_B(b8),
    .out_busy(busy8), .out_done(done8), .out_P(p8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full WIDTH=4 operation from the start pulse through the return to IDLE.
  task automatic run_op4(input string tag, input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
    a4 = a; b4 = b; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check({tag, " busy"}, 32'(busy4), 32'd1);
      check({tag, " no done"}, 32'(done4), 32'd0);
      check({tag, " P held"}, 32'(p4), 32'(prev_p));
      tick();
    end
    check({tag, " done"}, 32'(done4), 32'd1);
    check({tag, " busy low"}, 32'(busy4), 32'd0);
    check({tag, " P"}, 32'(p4), 32'(exp));
    prev_p = exp;
    tick();
    check({tag, " done low"}, 32'(done4), 32'd0);
    check({tag, " P kept"}, 32'(p4), 32'(exp));
  endtask

  initial begin
    tick();
    tick();
    check("reset busy", 32'(busy4), 32'd0);
    check("reset done", 32'(done4), 32'd0);
    check("reset P", 32'(p4), 32'd0);
    check("reset P8", 32'(p8), 32'd0);
    rst = 1'b0;
    tick();

`ifdef CLA_MULT_SIGNED_EN
    run_op4("m3x5", 4'hD, 4'h5, 8'hF1);
    run_op4("m8xm8", 4'h8, 4'h8, 8'h40);
    run_op4("m8x7", 4'h8, 4'h7, 8'hC8);
`else
    run_op4("13x11", 4'd13, 4'd11, 8'h8F);
    run_op4("15x15", 4'd15, 4'd15, 8'hE1);
    run_op4("0x9", 4'd0, 4'd9, 8'h00);

    // Start held through RUN with operands changed mid-operation, then held into DONE.
    a4 = 4'd13; b4 = 4'd11; start4 = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("b2b busy", 32'(busy4), 32'd1);
      if (i == 1) begin a4 = 4'd2; b4 = 4'd2; end
      tick();
    end
    check("b2b first done", 32'(done4), 32'd1);
    check("b2b first P", 32'(p4), 32'h8F);
    tick();
    start4 = 1'b0;
    check("b2b no bubble", 32'(busy4), 32'd1);
    check("b2b P held", 32'(p4), 32'h8F);
    for (int i = 0; i < 3; i++) tick();
    check("b2b last run", 32'(busy4), 32'd1);
    tick();
    check("b2b second done", 32'(done4), 32'd1);
    check("b2b second P", 32'(p4), 32'h04);
    tick();

    // Reset in the second RUN cycle aborts with no done pulse and clears P.
    a4 = 4'd7; b4 = 4'd7; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 32'(busy4), 32'd0);
    check("abort done", 32'(done4), 32'd0);
    check("abort P", 32'(p4), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort stays idle", 32'({busy4, done4}), 32'd0);
    end
    prev_p = 8'h00;
    run_op4("3x5", 4'd3, 4'd5, 8'h0F);

    // Reset and start together: reset wins.
    rst = 1'b1; start4 = 1'b1; a4 = 4'd3; b4 = 4'd3;
    tick();
    rst = 1'b0; start4 = 1'b0;
    check("rst beats start", 32'(busy4), 32'd0);
    check("rst beats start P", 32'(p4), 32'd0);
    tick();
    check("rst beats start idle", 32'(busy4), 32'd0);
`endif

    // WIDTH=8 all-ones operands: done and P valid nine cycles after the start cycle.
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("w8 busy", 32'(busy8), 32'd1);
      check("w8 no done", 32'(done8), 32'd0);
      tick();
    end
    check("w8 done", 32'(done8), 32'd1);
`ifdef CLA_MULT_SIGNED_EN
    check("w8 P", 32'(p8), 32'h0001);
`else
    check("w8 P", 32'(p8), 32'hFE01);
`endif
    tick();
    check("w8 done low", 32'(done8), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cla_shift_add_mult_ctrl.md
Name: cla_shift_add_mult_ctrl

Overview:
Sequential unsigned shift-and-add multiplier controller that time-shares one WIDTH-bit adder across WIDTH iterations. The adder is built from WIDTH/4 chained 4-bit CLA slices (Cin of the LSB slice = 0). The block sits in the multiplier datapath and exposes a start/busy/done handshake to the issuing logic.

Parameters:
WIDTH, 4, operand width in bits; must be a multiple of 4 and at least 4
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
in_start  input  1  request; sampled only in IDLE or DONE
in_A  input  WIDTH  multiplicand; sampled on the accepted-start edge
in_B  input  WIDTH  multiplier; sampled on the accepted-start edge
out_busy  output  1  high while state = RUN
out_done  output  1  one-cycle pulse when out_P becomes valid
out_P  output  2*WIDTH  product; held until the next accepted result

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset forces: state=IDLE, out_busy=0, out_done=0, out_P=0, internal registers and counter = 0.
- Internal registers:
  - M (WIDTH): multiplicand
  - ACC (WIDTH): high partial product
  - Q (WIDTH): multiplier, which shifts into the low product word
  - CNT (CNT_W): iteration counter
- States: IDLE, RUN, DONE.
- IDLE:
  - If in_start=1: M<=in_A, Q<=in_B, ACC<=0, CNT<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, one iteration per cycle:
  - sum = ACC + (Q[0] ? M : 0) through the CLA chain, carry-out c.
  - {ACC,Q} <= {c, sum, Q} >> 1, i.e. ACC<={c,sum[WIDTH-1:1]}, Q<={sum[0],Q[WIDTH-1:1]}.
  - CNT<=CNT+1.
  - When CNT==WIDTH-1 this cycle: out_P<=final {ACC,Q} value, out_done<=1, go to DONE.
- DONE, lasts exactly one cycle with out_done=1:
  - If in_start=1: accept a new operation exactly as in IDLE and go to RUN (back-to-back, no idle bubble).
  - Otherwise go to IDLE.
- out_done is 0 in every state except DONE.
- in_start in RUN is ignored. No queueing. in_A and in_B changes during RUN have no effect.
- Latency: start high in cycle c → out_busy high cycles c+1..c+WIDTH → out_done high and out_P valid in cycle c+WIDTH+1.
- Throughput: one product per WIDTH+1 cycles.
- out_P changes only on the DONE-entry edge or on reset. It is stable in IDLE and RUN, so a consumer may read it late.
- Width rules:
  - The product never exceeds 2*WIDTH bits, so there is no overflow.
  - The carry c is always shifted into ACC MSB and never dropped.
- Boundaries:
  - Operand 0 → product 0 after the full WIDTH iterations. There is no early termination.
  - All-ones operands → (2^WIDTH-1)^2.
  - rst asserted mid-RUN aborts the operation: no out_done pulse, out_P=0 next cycle.
  - rst and in_start in the same cycle: reset wins.

Optional Feature:
- Macro: CLA_MULT_SIGNED_EN.
- When defined, in_A, in_B and out_P are two's complement.
  - On accept: M<=|in_A|, Q<=|in_B|, and sign flag S<=in_A[WIDTH-1]^in_B[WIDTH-1].
  - On DONE entry: out_P<=S ? -{ACC,Q} : {ACC,Q}, where negation is 2*WIDTH-bit two's complement.
  - |−2^(WIDTH-1)| is treated as unsigned 2^(WIDTH-1) and yields the correct result.
  - Latency and handshake are unchanged.
- When undefined: purely unsigned behaviour; the S register and negation logic are absent.

Test Plan:
- WIDTH=4, in_A=13, in_B=11, start 1 cycle → out_busy high 4 cycles, out_done pulse in cycle 5 after start, out_P=8'h8F (143).
- in_A=15, in_B=15 → out_P=8'hE1. Then in_A=0, in_B=9 → out_P=8'h00 after full 4 iterations.
- in_start held high during RUN, with operands changed to 2,2 mid-operation → ignored; first result 13*11=143 unaffected. Start held into DONE → new op 2*2 accepted with no IDLE cycle, out_P=8'h04 five cycles later.
- rst asserted in 2nd RUN cycle of 7*7 → next cycle state IDLE, out_busy=0, out_P=0, no out_done pulse. Subsequent 3*5 → 8'h0F.
- WIDTH=8, in_A=8'hFF, in_B=8'hFF → out_P=16'hFE01 after 9 cycles.
- CLA_MULT_SIGNED_EN, WIDTH=4:
  - −3*5 (4'hD, 4'h5) → out_P=8'hF1.
  - −8*−8 → 8'h40.
  - −8*7 → 8'hC8.
